// File: rtl/pwm_capture_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int CNT_W_DEF       = 24;
    localparam int TIMEOUT_CYC_DEF = 2_500_000;
    localparam int FILTER_CYC_DEF  = 4;

    // clk_50 cycles per microsecond
    localparam int CYC_PER_US = 50;

endpackage

// File: rtl/pwm_capture_edge.sv
// Front end: 2-flop synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN), edge detector.
// Strobes and level are registered so the pwm_in-to-strobe latency is constant.
module pwm_capture_edge
    import pwm_capture_pkg::*;
#(
    parameter int FILTER_CYC = FILTER_CYC_DEF
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic pwm_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic sync_1;
    logic sync_2;
    logic src;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILTER_CYC + 1);

    logic [FW-1:0] stable_cnt;
    logic          filt;

    // The new level is taken on the FILTER_CYC-th consecutive sample that differs.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
            filt       <= 1'b0;
        end else if (sync_2 == filt) begin
            stable_cnt <= '0;
        end else if (stable_cnt == FW'(FILTER_CYC - 1)) begin
            filt       <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign src = filt;
`else
    logic unused_filter_cfg;

    assign unused_filter_cfg = (FILTER_CYC > 0);
    assign src               = sync_2;
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= src;
            rise  <= src & ~level;
            fall  <= ~src & level;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-line timeout and sticky bus flags.
// Build option: define PWM_CAPTURE_FILTER_EN to insert the glitch filter in the front end.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int FILTER_CYC  = FILTER_CYC_DEF
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             pwm_in,
    input  logic             clear,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             meas_new,
    output logic             overrun,
    output logic             timeout,
    output logic             level_out
);

    logic rise;
    logic fall;

    pwm_capture_edge #(
        .FILTER_CYC (FILTER_CYC)
    ) u_edge (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .pwm_in  (pwm_in),
        .rise    (rise),
        .fall    (fall),
        .level   (level_out)
    );

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_pend;
    logic             hit_to;
    logic             rise_acc;
    logic             do_fall_cap;
    logic             do_meas;
    logic             do_stuck;
    logic             do_idle_to;
    logic             update;

    assign hit_to = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Edges win over a timeout landing in the same cycle.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_next = HIGH;
                HIGH:    if (fall) state_next = LOW;  else if (hit_to) state_next = IDLE;
                LOW:     if (rise) state_next = HIGH; else if (hit_to) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rise_acc    = 1'b0;
        do_fall_cap = 1'b0;
        do_meas     = 1'b0;
        do_stuck    = 1'b0;
        do_idle_to  = 1'b0;
        if (!clear) begin
            case (state)
                IDLE: begin
                    rise_acc   = rise;
                    do_idle_to = hit_to && !rise;
                end
                HIGH: begin
                    do_fall_cap = fall;
                    do_stuck    = !fall && hit_to;
                end
                LOW: begin
                    rise_acc = rise;
                    do_meas  = rise;
                    do_stuck = !rise && hit_to;
                end
                default: ;
            endcase
        end
    end

    assign update = do_meas | do_stuck;

    // Saturating counter; the IDLE timeout fires once because cnt only moves up past it.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || rise_acc) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            high_pend  <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            meas_new   <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else if (clear) begin
            high_pend  <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            meas_new   <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= update;
            if (do_fall_cap) high_pend <= cnt + 1'b1;
            if (do_meas) begin
                period_out <= cnt + 1'b1;
                high_out   <= high_pend;
            end else if (do_stuck) begin
                period_out <= '0;
                high_out   <= '0;
            end
            if (do_stuck || do_idle_to) begin
                timeout <= 1'b1;
            end else if (rise_acc) begin
                timeout <= 1'b0;
            end
            // An ack coinciding with an update keeps the new result flagged.
            if (update) begin
                meas_new <= 1'b1;
                if (meas_new && !meas_ack) overrun <= 1'b1;
            end else if (meas_ack) begin
                meas_new <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed + randomized bench for pwm_capture; expected results come from a segment-level
// waveform model (rise-to-rise periods, rise-to-fall highs) kept entirely in the bench.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int CW = 16;
    localparam int TO = 6000;
    localparam int FC = FILTER_CYC_DEF;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 3 + FC;
`else
    localparam int LAT = 3;
`endif

    logic          clk_50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic          clear = 1'b0;
    logic          meas_ack = 1'b0;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          meas_valid;
    logic          meas_new;
    logic          overrun;
    logic          timeout;
    logic          level_out;

    int total = 0;
    int bad = 0;

    logic [2*CW-1:0] exp_q[$];
    logic [2*CW-1:0] got_q[$];
    logic            seg_v[$];
    int              seg_d[$];
    logic            seg_start;

    pwm_capture #(
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO),
        .FILTER_CYC  (FC)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .clear      (clear),
        .meas_ack   (meas_ack),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .meas_new   (meas_new),
        .overrun    (overrun),
        .timeout    (timeout),
        .level_out  (level_out)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (meas_valid) got_q.push_back({period_out, high_out});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic seg(input logic v, input int n);
        seg_v.push_back(v);
        seg_d.push_back(n);
        pwm_in = v;
        repeat (n) @(negedge clk_50);
    endtask

    task automatic begin_burst(input logic lvl);
        seg_start = lvl;
        seg_v.delete();
        seg_d.delete();
        got_q.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk_50);
        clear = 1'b0;
    endtask

    // The ack cycle is line time too, so it lengthens the current segment.
    task automatic pulse_ack();
        meas_ack = 1'b1;
        @(negedge clk_50);
        meas_ack = 1'b0;
        if (seg_d.size() > 0) seg_d[seg_d.size()-1] = seg_d[seg_d.size()-1] + 1;
    endtask

    task automatic model_segs();
        logic fv[$];
        int   fd[$];
        int   rises[$];
        int   falls[$];
        logic cur;
        int   t;
        int   hi;
        for (int i = 0; i < seg_v.size(); i++) begin
            logic v;
            v = seg_v[i];
`ifdef PWM_CAPTURE_FILTER_EN
            if (seg_d[i] < FC) v = (fv.size() > 0) ? fv[fv.size()-1] : seg_start;
`endif
            if (fv.size() > 0 && fv[fv.size()-1] == v) begin
                fd[fd.size()-1] = fd[fd.size()-1] + seg_d[i];
            end else begin
                fv.push_back(v);
                fd.push_back(seg_d[i]);
            end
        end
        cur = seg_start;
        t = 0;
        for (int i = 0; i < fv.size(); i++) begin
            if (!cur && fv[i]) rises.push_back(t);
            if (cur && !fv[i]) falls.push_back(t);
            cur = fv[i];
            t = t + fd[i];
        end
        exp_q.delete();
        for (int k = 0; k + 1 < rises.size(); k++) begin
            hi = 0;
            for (int j = 0; j < falls.size(); j++) begin
                if (hi == 0 && falls[j] > rises[k]) hi = falls[j] - rises[k];
            end
            exp_q.push_back({CW'(rises[k+1] - rises[k]), CW'(hi)});
        end
    endtask

    task automatic check_burst(input string tag);
        model_segs();
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s period[%0d]", tag, i), got_q[i][2*CW-1:CW], exp_q[i][2*CW-1:CW]);
            check($sformatf("%s high[%0d]", tag, i), got_q[i][CW-1:0], exp_q[i][CW-1:0]);
        end
        got_q.delete();
    endtask

    initial begin
        logic [31:0] first;

        // reset state
        idle(3);
        check("rst period", period_out, 0);
        check("rst high", high_out, 0);
        check("rst valid", meas_valid, 0);
        check("rst new", meas_new, 0);
        check("rst overrun", overrun, 0);
        check("rst timeout", timeout, 0);
        check("rst level", level_out, 0);
        reset_n = 1'b1;
        idle(2);

        // 50% duty, 5 periods, never acked
        begin_burst(1'b0);
        for (int i = 0; i < 5; i++) begin
            seg(1'b1, 500);
            seg(1'b0, 500);
        end
        check_burst("duty50");
        check("duty50 new", meas_new, 1);
        check("duty50 overrun", overrun, 1);

        do_clear();
        check("clr period", period_out, 0);
        check("clr high", high_out, 0);
        check("clr new", meas_new, 0);
        check("clr overrun", overrun, 0);

        // random pulse train
        begin_burst(1'b0);
        for (int i = 0; i < 6; i++) begin
            int h;
            int l;
            h = $urandom_range(400, 8);
            l = $urandom_range(400, 8);
            seg(1'b1, h);
            seg(1'b0, l);
        end
        seg(1'b1, 20);
        seg(1'b0, 20);
        check_burst("rand");

        // idle timeout: flag only, no measurement
        do_clear();
        got_q.delete();
        idle(TO + 100);
        check("idle_to timeout", timeout, 1);
        check("idle_to no meas", got_q.size(), 0);
        check("idle_to level", level_out, 0);

        // servo-style waveform (scaled); first rise clears the idle timeout
        begin_burst(1'b0);
        seg(1'b1, 375);
        seg(1'b0, 4625);
        seg(1'b1, 400);
        check_burst("servo");
        check("servo timeout", timeout, 0);

        // stuck high
        idle(7000);
        first = (got_q.size() > 0) ? 32'(got_q[0]) : 32'hffff_ffff;
        check("stuck meas count", got_q.size(), 1);
        check("stuck meas value", first, 0);
        check("stuck timeout", timeout, 1);
        check("stuck level", level_out, 1);
        check("stuck period", period_out, 0);
        check("stuck high", high_out, 0);

        begin_burst(1'b1);
        seg(1'b0, 300);
        seg(1'b1, 200);
        seg(1'b0, 800);
        seg(1'b1, 200);
        seg(1'b0, 50);
        check_burst("restore");
        check("restore timeout", timeout, 0);

        // flags
        do_clear();
        begin_burst(1'b0);
        seg(1'b1, 100);
        seg(1'b0, 100);
        seg(1'b1, 100);
        check("flag1 new", meas_new, 1);
        check("flag1 overrun", overrun, 0);
        seg(1'b0, 100);
        seg(1'b1, 100);
        check("flag2 new", meas_new, 1);
        check("flag2 overrun", overrun, 1);
        pulse_ack();
        check("ack new", meas_new, 0);
        check("ack overrun", overrun, 0);
        seg(1'b0, 100);
        seg(1'b1, 100);
        check("flag3 new", meas_new, 1);
        check("flag3 overrun", overrun, 0);
        seg(1'b0, 100);
        // ack lands on the clock edge where the measurement is taken
        seg_v.push_back(1'b1);
        seg_d.push_back(100);
        pwm_in = 1'b1;
        idle(LAT);
        meas_ack = 1'b1;
        @(negedge clk_50);
        meas_ack = 1'b0;
        idle(100 - LAT - 1);
        check("ack_same new", meas_new, 1);
        check("ack_same overrun", overrun, 0);
        seg(1'b0, 100);
        check_burst("flags");

        // asynchronous reset in the middle of a high phase
        pwm_in = 1'b1;
        idle(50);
        #2 reset_n = 1'b0;
        #1;
        check("async period", period_out, 0);
        check("async high", high_out, 0);
        check("async new", meas_new, 0);
        check("async level", level_out, 0);
        @(negedge clk_50);
        reset_n = 1'b1;
        begin_burst(1'b0);
        seg(1'b1, 150);
        check("post_rst first rise", got_q.size(), 0);
        seg(1'b0, 300);
        seg(1'b1, 200);
        seg(1'b0, 100);
        check_burst("post_rst");

        // short low glitch inside the high phase
        do_clear();
        begin_burst(1'b0);
        for (int i = 0; i < 2; i++) begin
            seg(1'b1, 200);
            seg(1'b0, 2);
            seg(1'b1, 298);
            seg(1'b0, 500);
        end
        seg(1'b1, 50);
        seg(1'b0, 50);
        check_burst("glitch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
